// File: rtl/tt_um_ternary_mac_if.sv
// Bundle of the ternary MAC's data/handshake signals, shared by the loader side and the MAC.
//   ena             module select; low aborts the current vector
//   ui_weights      flattened 2-bit ternary weights, element (i,j) at [2*(i*MAX_OUT_LEN+j) +: 2]
//   ui_load_done    loader done pulse (arms the MAC; aborts an in-flight vector)
//   ui_param        [6:3] active rows n_in, [2:0] last output column
//   ui_act          signed 8-bit activation
//   ui_act_valid    activation strobe
//   uo_result       signed 8-bit column result
//   uo_result_valid uo_result holds a result this cycle
//   uo_busy         vector in progress (accumulating or draining)
// master: upstream/pin side that drives the inputs; slave: the MAC.
interface tt_um_ternary_mac_if #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8
);
  logic                                 ena;
  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]  ui_weights;
  logic                                 ui_load_done;
  logic [6:0]                           ui_param;
  logic [7:0]                           ui_act;
  logic                                 ui_act_valid;
  logic [7:0]                           uo_result;
  logic                                 uo_result_valid;
  logic                                 uo_busy;

  modport master (
    output ena, ui_weights, ui_load_done, ui_param, ui_act, ui_act_valid,
    input  uo_result, uo_result_valid, uo_busy
  );

  modport slave (
    input  ena, ui_weights, ui_load_done, ui_param, ui_act, ui_act_valid,
    output uo_result, uo_result_valid, uo_busy
  );
endinterface

// File: rtl/tt_um_ternary_mac.sv
// Ternary-weight multiply-accumulate stage.
// Accumulates a stream of signed 8-bit activations against a 2-bit ternary weight matrix,
// all output columns in parallel, then drains the column sums one per cycle.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    tt_um_ternary_mac_if.slave (weights, params, activations in; results, busy out)
// Configuration macro:
//   SATURATE_EN  defined: results saturate to [-128, 127]; undefined: results wrap (acc[7:0]).
module tt_um_ternary_mac #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int ACC_WIDTH   = 13
) (
  input logic                clk,
  input logic                rst_n,
  tt_um_ternary_mac_if.slave bus
);

  localparam int ColW = $clog2(MAX_OUT_LEN);
  localparam logic signed [ACC_WIDTH-1:0] SatMax = ACC_WIDTH'(127);
  localparam logic signed [ACC_WIDTH-1:0] SatMin = -ACC_WIDTH'(128);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  state_e                      state_q;
  logic                        load_seen_q;
  logic                        armed_q;
  logic [3:0]                  row_q;
  logic [3:0]                  n_in_q;
  logic [3:0]                  col_q;
  logic [3:0]                  n_out_q;
  logic signed [ACC_WIDTH-1:0] acc_q [MAX_OUT_LEN];
  logic [7:0]                  result_q;
  logic                        result_valid_q;
  logic                        busy_q;

  logic                        accept;
  logic                        abort;
  logic                        last_row;
  logic [3:0]                  n_in_eff;
  logic signed [ACC_WIDTH-1:0] act_ext;
  logic signed [ACC_WIDTH-1:0] acc_upd [MAX_OUT_LEN];
  logic signed [ACC_WIDTH-1:0] acc_sel;

  function automatic logic signed [ACC_WIDTH-1:0] term(input logic [1:0] w,
                                                       input logic signed [ACC_WIDTH-1:0] x);
    case (w)
      2'b01:   term = x;
      2'b11:   term = -x;
      default: term = '0;
    endcase
  endfunction

  function automatic logic [7:0] fmt(input logic signed [ACC_WIDTH-1:0] v);
`ifdef SATURATE_EN
    if (v > SatMax) begin
      fmt = 8'h7f;
    end else if (v < SatMin) begin
      fmt = 8'h80;
    end else begin
      fmt = v[7:0];
    end
`else
    fmt = v[7:0];
`endif
  endfunction

  always_comb begin
    accept   = bus.ena & armed_q & bus.ui_act_valid & (state_q != StDrain);
    abort    = ~bus.ena | (bus.ui_load_done & (state_q != StIdle));
    // In IDLE the params are not latched yet, so the row-count test uses the live pins.
    n_in_eff = (state_q == StIdle) ? bus.ui_param[6:3] : n_in_q;
    last_row = (row_q + 4'd1) == n_in_eff;
    act_ext  = ACC_WIDTH'(signed'(bus.ui_act));
    // Only the current row is indexed, so weights of unused rows never reach the accumulators.
    for (int j = 0; j < MAX_OUT_LEN; j++) begin
      acc_upd[j] = acc_q[j] + term(bus.ui_weights[2*(int'(row_q)*MAX_OUT_LEN + j) +: 2], act_ext);
    end
    acc_sel  = acc_q[col_q[ColW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      load_seen_q    <= 1'b0;
      armed_q        <= 1'b0;
      row_q          <= '0;
      n_in_q         <= '0;
      col_q          <= '0;
      n_out_q        <= '0;
      for (int j = 0; j < MAX_OUT_LEN; j++) acc_q[j] <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      // Two-stage arming mirrors the loader's one-cycle settle after its done pulse.
      load_seen_q <= bus.ui_load_done;
      if (load_seen_q) armed_q <= 1'b1;

      if (abort) begin
        state_q        <= StIdle;
        row_q          <= '0;
        col_q          <= '0;
        for (int j = 0; j < MAX_OUT_LEN; j++) acc_q[j] <= '0;
        result_valid_q <= 1'b0;
        busy_q         <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              n_in_q  <= bus.ui_param[6:3];
              n_out_q <= {1'b0, bus.ui_param[2:0]} + 4'd1;
              busy_q  <= 1'b1;
              if (bus.ui_param[6:3] == 4'd0) begin
                state_q <= StDrain;
              end else begin
                acc_q   <= acc_upd;
                row_q   <= 4'd1;
                state_q <= last_row ? StDrain : StAccum;
              end
            end
          end
          StAccum: begin
            if (accept) begin
              acc_q <= acc_upd;
              row_q <= row_q + 4'd1;
              if (last_row) state_q <= StDrain;
            end
          end
          StDrain: begin
            if (col_q < n_out_q) begin
              result_q       <= fmt(acc_sel);
              result_valid_q <= 1'b1;
              col_q          <= col_q + 4'd1;
            end else begin
              // Extra cycle after the last column drops valid and busy together.
              state_q        <= StIdle;
              row_q          <= '0;
              col_q          <= '0;
              for (int j = 0; j < MAX_OUT_LEN; j++) acc_q[j] <= '0;
              result_valid_q <= 1'b0;
              busy_q         <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.uo_result       = result_q;
  assign bus.uo_result_valid = result_valid_q;
  assign bus.uo_busy         = busy_q;

endmodule

// File: tb/tb_tt_um_ternary_mac.sv
module tb_tt_um_ternary_mac;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tt_um_ternary_mac_if #(.MAX_IN_LEN(16), .MAX_OUT_LEN(8)) bus ();

  tt_um_ternary_mac #(.MAX_IN_LEN(16), .MAX_OUT_LEN(8), .ACC_WIDTH(13)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         wv  [16][8];
  int         acts[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Weight model: code drives the pins, wv holds its ternary value.
  task automatic set_code(input int i, input int j, input logic [1:0] code);
    bus.ui_weights[2*(i*8+j) +: 2] = code;
    wv[i][j] = (code == 2'b01) ? 1 : (code == 2'b11) ? -1 : 0;
  endtask

  task automatic set_val(input int i, input int j, input int v);
    logic [1:0] code;
    if (v > 0)      code = 2'b01;
    else if (v < 0) code = 2'b11;
    else            code = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
    set_code(i, j, code);
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 8; j++) set_val(i, j, v);
  endtask

  function automatic logic [7:0] fmt(input int s);
    logic [31:0] u;
    u = s;
`ifdef SATURATE_EN
    if (s > 127)  return 8'h7f;
    if (s < -128) return 8'h80;
`endif
    return u[7:0];
  endfunction

  task automatic push_expected(input int n_in, input int lc);
    for (int j = 0; j <= lc; j++) begin
      int s;
      s = 0;
      for (int i = 0; i < n_in; i++) s += wv[i][j] * acts[i];
      exp_q.push_back(fmt(s));
    end
  endtask

  // Valid and busy must be high for exactly n cycles after the accepting edge, then both low.
  task automatic check_drain(input int n);
    for (int k = 0; k < n; k++) begin
      cyc();
      chk("drain_active", {30'b0, bus.uo_result_valid, bus.uo_busy}, 32'h3);
    end
    cyc();
    chk("drain_end", {30'b0, bus.uo_result_valid, bus.uo_busy}, 32'h0);
  endtask

  task automatic run_vec(input int n_in, input int lc, input bit gaps);
    int nacts;
    push_expected(n_in, lc);
    bus.ui_param = {n_in[3:0], lc[2:0]};
    nacts = (n_in == 0) ? 1 : n_in;
    for (int i = 0; i < nacts; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.ui_act_valid = 1'b0;
          bus.ui_act       = 8'($urandom);
          cyc();
        end
      end
      bus.ui_act       = 8'(acts[i]);
      bus.ui_act_valid = 1'b1;
      cyc();
      // Params are latched at the first acceptance; later changes must be ignored.
      if (gaps) bus.ui_param = 7'($urandom);
    end
    bus.ui_act_valid = 1'b0;
    check_drain(lc + 1);
  endtask

  // Monitor: every presented result must match the next queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.uo_result_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result got=%0d required=no_result", $signed(bus.uo_result));
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.uo_result !== e) begin
            failures++;
            $display("FAIL result got=%0d required=%0d", $signed(bus.uo_result), $signed(e));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus.ena          = 1'b0;
    bus.ui_weights   = '0;
    bus.ui_load_done = 1'b0;
    bus.ui_param     = '0;
    bus.ui_act       = '0;
    bus.ui_act_valid = 1'b0;
    repeat (3) cyc();
    chk("reset_outputs", {22'b0, bus.uo_result, bus.uo_result_valid, bus.uo_busy}, 32'h0);
    rst_n = 1'b1;
    cyc();
    chk("post_reset_outputs", {22'b0, bus.uo_result, bus.uo_result_valid, bus.uo_busy}, 32'h0);

    // Arming: activations before any load_done are ignored.
    bus.ena = 1'b1;
    set_all(1);
    bus.ui_param     = {4'd1, 3'd0};
    bus.ui_act       = 8'd7;
    bus.ui_act_valid = 1'b1;
    repeat (3) begin
      cyc();
      chk("unarmed_busy", {31'b0, bus.uo_busy}, 32'h0);
    end
    bus.ui_act_valid = 1'b0;
    bus.ui_load_done = 1'b1;
    cyc();
    bus.ui_load_done = 1'b0;
    bus.ui_act_valid = 1'b1;
    cyc();
    chk("arm_second_edge_ignored", {31'b0, bus.uo_busy}, 32'h0);
    acts[0] = 7;
    push_expected(1, 0);
    cyc();
    bus.ui_act_valid = 1'b0;
    check_drain(1);

    // Basic sum: all +1, 10+20+30+40 on two columns.
    acts[0] = 10; acts[1] = 20; acts[2] = 30; acts[3] = 40;
    run_vec(4, 1, 1'b0);

    // Mixed signs.
    set_all(0);
    set_code(0, 0, 2'b01); set_code(1, 0, 2'b11); set_code(2, 0, 2'b00); set_code(3, 0, 2'b10);
    for (int i = 0; i < 4; i++) set_code(i, 1, 2'b11);
    acts[0] = 5; acts[1] = 3; acts[2] = 7; acts[3] = 9;
    run_vec(4, 1, 1'b0);

    // Saturation / wrap, both signs.
    for (int i = 0; i < 16; i++) acts[i] = 127;
    set_all(1);
    run_vec(15, 0, 1'b0);
    set_all(-1);
    run_vec(15, 0, 1'b0);

    // Abort by ena after two of four activations, then rerun.
    set_all(1);
    bus.ui_param     = {4'd4, 3'd1};
    bus.ui_act_valid = 1'b1;
    bus.ui_act       = 8'd10;
    cyc();
    bus.ui_act       = 8'd20;
    cyc();
    bus.ui_act_valid = 1'b0;
    bus.ena          = 1'b0;
    cyc();
    chk("abort_ena_busy", {31'b0, bus.uo_busy}, 32'h0);
    bus.ena = 1'b1;
    repeat (3) begin
      cyc();
      chk("abort_ena_idle", {30'b0, bus.uo_result_valid, bus.uo_busy}, 32'h0);
    end
    acts[0] = 10; acts[1] = 20; acts[2] = 30; acts[3] = 40;
    run_vec(4, 1, 1'b0);

    // Abort by load_done mid-DRAIN: only the first two columns appear.
    acts[0] = 9;
    exp_q.push_back(fmt(9));
    exp_q.push_back(fmt(9));
    bus.ui_param     = {4'd1, 3'd7};
    bus.ui_act       = 8'd9;
    bus.ui_act_valid = 1'b1;
    cyc();
    bus.ui_act_valid = 1'b0;
    repeat (2) begin
      cyc();
      chk("pre_abort_drain", {30'b0, bus.uo_result_valid, bus.uo_busy}, 32'h3);
    end
    bus.ui_load_done = 1'b1;
    cyc();
    bus.ui_load_done = 1'b0;
    chk("abort_load_done", {30'b0, bus.uo_result_valid, bus.uo_busy}, 32'h0);
    repeat (4) cyc();

    // Zero rows: three zero results from a single discarded activation.
    acts[0] = 55;
    run_vec(0, 2, 1'b0);

    // Randomized vectors; unused weight rows are X.
    for (int t = 0; t < 25; t++) begin
      int n_in;
      int lc;
      n_in = $urandom_range(0, 15);
      lc   = $urandom_range(0, 7);
      for (int i = 0; i < 16; i++) begin
        acts[i] = int'($signed(8'($urandom)));
        for (int j = 0; j < 8; j++) begin
          if (i < n_in) set_val(i, j, $urandom_range(0, 2) - 1);
          else          bus.ui_weights[2*(i*8+j) +: 2] = 2'bxx;
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < n_in; i++) acts[i] = ($urandom_range(0, 1) != 0) ? 127 : -128;
      end
      run_vec(n_in, lc, 1'b1);
    end

    repeat (3) cyc();
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
